// File: rtl/rv32i_load_store_unit.sv
// Memory-access stage of the multi-cycle RV32I core: one req/ack data-bus transfer per start,
// with store lane steering, load extraction and a bounded wait for the acknowledge.
module rv32i_load_store_unit #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        busy,
    output logic [1:0]  fault
);

    localparam int CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        FINISH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       lat_funct3;
    logic [1:0]       lat_off;
    logic             illegal;
    logic             misaligned;
    logic             timed_out;

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   store_lanes = {4{data[7:0]}};
            2'b01:   store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   store_strobe = 4'b0001 << off;
            2'b01:   store_strobe = 4'b0011 << off;
            default: store_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0]        lane;
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        lane   = word >> {off, 3'b000};
        lane_b = signed'(lane[7:0]);
        lane_h = signed'(lane[15:0]);
        case (f3)
            3'b000:  load_extend = 32'(lane_b);
            3'b001:  load_extend = 32'(lane_h);
            3'b100:  load_extend = {24'b0, lane[7:0]};
            3'b101:  load_extend = {16'b0, lane[15:0]};
            default: load_extend = lane;
        endcase
    endfunction

    // Unsigned widths only exist for loads; stores reject them as illegal.
    always_comb begin
        illegal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = is_store;
            default:                illegal = 1'b1;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            3'b001, 3'b101: misaligned = addr[0];
            3'b010:         misaligned = (addr[1:0] != 2'b00);
            default:        misaligned = 1'b0;
        endcase
    end

    assign timed_out = (BUS_TIMEOUT != 0) && (wait_cnt == LAST_CNT);

    // Width and byte offset are only needed to extract the read word later.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            lat_funct3 <= funct3;
            lat_off    <= addr[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            load_data <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            fault     <= FAULT_OK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        fault <= FAULT_OK;
                        state <= FINISH;
                        if (!is_load && !is_store) begin
                            fault <= FAULT_OK;
                        end else if (illegal) begin
                            fault <= FAULT_ILLEGAL;
                        end else if (misaligned) begin
                            fault <= FAULT_MISALIGN;
                        end else begin
                            state     <= ACCESS;
                            wait_cnt  <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= is_store ? store_lanes(funct3[1:0], rs2) : 32'h0;
                            mem_wstrb <= is_store ? store_strobe(funct3[1:0], addr[1:0]) : 4'h0;
                        end
                    end
                end
                ACCESS: begin
                    // An acknowledge in the final counted cycle still completes the transfer.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            load_data <= load_extend(lat_funct3, lat_off, mem_rdata);
                        end
                        state <= FINISH;
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        fault   <= FAULT_TIMEOUT;
                        state   <= FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Directed bench for rv32i_load_store_unit: a short-timeout instance and a wait-forever
// instance share the bus inputs but have separate start strobes.
module tb_rv32i_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        req_a, we_a, done_a, busy_a;
    logic [31:0] maddr_a, wdata_a, ld_a;
    logic [3:0]  wstrb_a;
    logic [1:0]  fault_a;

    logic        req_b, we_b, done_b, busy_b;
    logic [31:0] maddr_b, wdata_b, ld_b;
    logic [3:0]  wstrb_b;
    logic [1:0]  fault_b;

    int tests = 0;
    int fails = 0;
    int hi_cycles;

    rv32i_load_store_unit #(.BUS_TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .rs2(rs2), .mem_req(req_a), .mem_we(we_a),
        .mem_addr(maddr_a), .mem_wdata(wdata_a), .mem_wstrb(wstrb_a), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .load_data(ld_a), .done(done_a), .busy(busy_a), .fault(fault_a)
    );

    rv32i_load_store_unit #(.BUS_TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .rs2(rs2), .mem_req(req_b), .mem_we(we_b),
        .mem_addr(maddr_b), .mem_wdata(wdata_b), .mem_wstrb(wstrb_b), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .load_data(ld_b), .done(done_b), .busy(busy_b), .fault(fault_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d);
        is_load  = ld;
        is_store = st;
        funct3   = f;
        addr     = a;
        rs2      = d;
    endtask

    // Bus transfer on instance A with an acknowledge in the first ACCESS cycle.
    task automatic run_ok(input string tag, input logic ld, input logic st, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [31:0] e_wdata,
                          input logic [3:0] e_wstrb, input logic [31:0] e_load);
        set_op(ld, st, f, a, d);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({tag, ".req"},   32'(req_a),   32'd1);
        check({tag, ".we"},    32'(we_a),    32'(st));
        check({tag, ".addr"},  maddr_a,      e_addr);
        check({tag, ".wdata"}, wdata_a,      e_wdata);
        check({tag, ".wstrb"}, 32'(wstrb_a), 32'(e_wstrb));
        check({tag, ".busy"},  32'(busy_a),  32'd1);
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check({tag, ".req_drop"}, 32'(req_a), 32'd0);
        check({tag, ".load"},     ld_a,       e_load);
        check({tag, ".done_lo"},  32'(done_a), 32'd0);
        tick();
        check({tag, ".done"},  32'(done_a),  32'd1);
        check({tag, ".busy0"}, 32'(busy_a),  32'd0);
        check({tag, ".fault"}, 32'(fault_a), 32'd0);
    endtask

    // Start on instance A that must finish without touching the bus.
    task automatic run_nobus(input string tag, input logic ld, input logic st, input logic [2:0] f,
                             input logic [31:0] a, input logic [1:0] e_fault,
                             input logic [31:0] e_load);
        set_op(ld, st, f, a, 32'h5555AAAA);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({tag, ".req0"},  32'(req_a),  32'd0);
        check({tag, ".busy"},  32'(busy_a), 32'd1);
        check({tag, ".done0"}, 32'(done_a), 32'd0);
        tick();
        check({tag, ".done"},  32'(done_a),  32'd1);
        check({tag, ".req1"},  32'(req_a),   32'd0);
        check({tag, ".fault"}, 32'(fault_a), 32'(e_fault));
        check({tag, ".load"},  ld_a,         e_load);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst.req",   32'(req_a),   32'd0);
        check("rst.we",    32'(we_a),    32'd0);
        check("rst.addr",  maddr_a,      32'd0);
        check("rst.wdata", wdata_a,      32'd0);
        check("rst.wstrb", 32'(wstrb_a), 32'd0);
        check("rst.load",  ld_a,         32'd0);
        check("rst.done",  32'(done_a),  32'd0);
        check("rst.busy",  32'(busy_a),  32'd0);
        check("rst.fault", 32'(fault_a), 32'd0);
        check("rst.req_b", 32'(req_b),   32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle.busy", 32'(busy_a), 32'd0);

        // Stores: lane replication and strobes.
        run_ok("sb", 1'b0, 1'b1, 3'b000, 32'h103, 32'h123456A5, 32'h0,
               32'h100, 32'hA5A5A5A5, 4'b1000, 32'h0);
        run_ok("sh", 1'b0, 1'b1, 3'b001, 32'h202, 32'hCAFEBEEF, 32'h0,
               32'h200, 32'hBEEFBEEF, 4'b1100, 32'h0);
        run_ok("sw", 1'b0, 1'b1, 3'b010, 32'h300, 32'h12345678, 32'h0,
               32'h300, 32'h12345678, 4'b1111, 32'h0);

        // Loads: extraction and extension.
        run_ok("lb", 1'b1, 1'b0, 3'b000, 32'h2, 32'h0, 32'h00800000,
               32'h0, 32'h0, 4'b0000, 32'hFFFFFF80);
        run_ok("lbu", 1'b1, 1'b0, 3'b100, 32'h2, 32'h0, 32'h00800000,
               32'h0, 32'h0, 4'b0000, 32'h00000080);
        run_ok("lh", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80010000,
               32'h200, 32'h0, 4'b0000, 32'hFFFF8001);
        run_ok("lhu", 1'b1, 1'b0, 3'b101, 32'h6, 32'h0, 32'hF00F1234,
               32'h4, 32'h0, 4'b0000, 32'h0000F00F);
        run_ok("lw", 1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF,
               32'h8, 32'h0, 4'b0000, 32'hDEADBEEF);
        run_ok("lb_pos", 1'b1, 1'b0, 3'b000, 32'h1, 32'h0, 32'h00007F00,
               32'h0, 32'h0, 4'b0000, 32'h0000007F);
        run_ok("lbu3", 1'b1, 1'b0, 3'b100, 32'h3, 32'h0, 32'hAB000000,
               32'h0, 32'h0, 4'b0000, 32'h000000AB);

        // Faults without bus activity; load_data keeps the last load.
        run_nobus("lh_mis", 1'b1, 1'b0, 3'b001, 32'h1,   2'b01, 32'h000000AB);
        run_nobus("lw_mis", 1'b1, 1'b0, 3'b010, 32'h2,   2'b01, 32'h000000AB);
        run_nobus("sw_mis", 1'b0, 1'b1, 3'b010, 32'h101, 2'b01, 32'h000000AB);
        run_nobus("ld_011", 1'b1, 1'b0, 3'b011, 32'h0,   2'b11, 32'h000000AB);
        run_nobus("st_100", 1'b0, 1'b1, 3'b100, 32'h0,   2'b11, 32'h000000AB);
        run_nobus("ld_111", 1'b1, 1'b0, 3'b111, 32'h0,   2'b11, 32'h000000AB);
        run_nobus("none",   1'b0, 1'b0, 3'b010, 32'h3,   2'b00, 32'h000000AB);

        // Timeout on instance A (BUS_TIMEOUT=4).
        set_op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        hi_cycles = 0;
        for (int i = 0; i < 10 && req_a; i++) begin
            hi_cycles++;
            tick();
        end
        check("to.req_cycles", 32'(hi_cycles), 32'd4);
        check("to.req0",   32'(req_a),   32'd0);
        check("to.fault",  32'(fault_a), 32'd2);
        check("to.busy",   32'(busy_a),  32'd1);
        check("to.done0",  32'(done_a),  32'd0);
        tick();
        check("to.done",   32'(done_a),  32'd1);
        check("to.fault2", 32'(fault_a), 32'd2);
        check("to.load",   ld_a,         32'h000000AB);
        tick();
        check("to.done_end", 32'(done_a), 32'd0);

        // Slow acknowledge on instance B with a start while busy.
        set_op(1'b0, 1'b1, 3'b010, 32'h40, 32'h89ABCDEF);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("slow.req", 32'(req_b), 32'd1);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                set_op(1'b1, 1'b0, 3'b000, 32'h81, 32'h0);
                start_b = 1'b1;
            end
            tick();
            start_b = 1'b0;
            check("slow.req_held", 32'(req_b),   32'd1);
            check("slow.addr",     maddr_b,      32'h40);
            check("slow.wdata",    wdata_b,      32'h89ABCDEF);
            check("slow.wstrb",    32'(wstrb_b), 32'hF);
            check("slow.we",       32'(we_b),    32'd1);
            check("slow.done0",    32'(done_b),  32'd0);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("slow.req_drop", 32'(req_b),  32'd0);
        check("slow.done_lo",  32'(done_b), 32'd0);
        tick();
        check("slow.done",  32'(done_b),  32'd1);
        check("slow.fault", 32'(fault_b), 32'd0);
        check("slow.busy0", 32'(busy_b),  32'd0);
        tick();
        check("slow.no_second_req",  32'(req_b),  32'd0);
        check("slow.no_second_busy", 32'(busy_b), 32'd0);
        check("slow.a_ignores_ack",  ld_a,        32'h000000AB);
        check("slow.a_idle",         32'(req_a),  32'd0);

        // Asynchronous reset in the middle of a transfer.
        set_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("arst.req_before", 32'(req_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.req_now", 32'(req_a),  32'd0);
        check("arst.busy",    32'(busy_a), 32'd0);
        check("arst.load",    ld_a,        32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst.busy_after",  32'(busy_a),  32'd0);
        check("arst.done_after",  32'(done_a),  32'd0);
        check("arst.fault_after", 32'(fault_a), 32'd0);
        check("arst.req_after",   32'(req_a),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
